// File: rtl/rw_gpio_pkg.sv
// -----------------------------------------------------------------------------
// rw_gpio_pkg
//   Shared constants and types for the ZedBoard GPIO slice.
//   - GPIO_IN_WIDTH / GPIO_OUT_WIDTH : pin counts on the input (sw + btn) and
//     output (led) sides of the GPIO peripheral.
//   - CLK_HZ / DEBOUNCE_1MS          : system clock and the 1 ms debounce window
//     expressed in clk cycles.
//   - DEBOUNCE_CNT_W                 : counter width able to hold DEBOUNCE_1MS-1.
//   - db_action_e                    : per-cycle decision of a debounce counter.
// -----------------------------------------------------------------------------
package rw_gpio_pkg;

    localparam int unsigned GPIO_IN_WIDTH  = 13;
    localparam int unsigned GPIO_OUT_WIDTH = 8;
    localparam int unsigned CLK_HZ         = 125_000_000;
    localparam int unsigned DEBOUNCE_1MS   = CLK_HZ / 1000;

    // 2**17 = 131072 > 125000
    localparam int unsigned DEBOUNCE_CNT_W = 17;

    // What a debounce counter does on the current clk edge.
    //   DB_IDLE   : synchronised input matches the accepted level, count restarts
    //   DB_COUNT  : input differs, still inside the stability window
    //   DB_ACCEPT : input has differed for the full window, adopt it
    typedef enum logic [1:0] {
        DB_IDLE   = 2'd0,
        DB_COUNT  = 2'd1,
        DB_ACCEPT = 2'd2
    } db_action_e;

endpackage : rw_gpio_pkg

// File: rtl/gpio_debounce_bit.sv
// -----------------------------------------------------------------------------
// gpio_debounce_bit
//   Conditions one raw board pin: metastability synchroniser, debounce counter,
//   accepted-level flop and registered edge pulses.
//
//   Parameters
//     SYNC_STAGES      synchroniser depth (min 2)
//     DEBOUNCE_CYCLES  consecutive stable cycles needed to accept a new level
//     CNT_W            counter width, 2**CNT_W > DEBOUNCE_CYCLES
//
//   Ports
//     clk         in   system clock
//     rst_n       in   asynchronous active-low reset
//     pin         in   raw asynchronous pin
//     stable      out  debounced level
//     rise_pulse  out  one-cycle pulse, the cycle after stable goes 0->1
//     fall_pulse  out  one-cycle pulse, the cycle after stable goes 1->0
// -----------------------------------------------------------------------------
module gpio_debounce_bit
    import rw_gpio_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_1MS,
    parameter int unsigned CNT_W           = DEBOUNCE_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic stable,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic [CNT_W-1:0]       cnt;
    logic                   stable_prev;
    db_action_e             action;

    // ---------------------------------------------------------------------
    // Synchroniser: sync is the pin delayed by SYNC_STAGES clk.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
        end
    end

    always_comb begin
        sync = sync_q[SYNC_STAGES-1];
    end

    // ---------------------------------------------------------------------
    // Debounce decision. The count only advances while the input disagrees
    // with the accepted level, so any return to agreement (a glitch ending)
    // restarts the window; cnt stops at CNT_LAST and cannot wrap.
    // ---------------------------------------------------------------------
    always_comb begin
        action = DB_IDLE;
        if (sync != stable) begin
            if (cnt == CNT_LAST) begin
                action = DB_ACCEPT;
            end else begin
                action = DB_COUNT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else begin
            unique case (action)
                DB_IDLE: begin
                    cnt <= '0;
                end
                DB_COUNT: begin
                    cnt <= cnt + CNT_W'(1);
                end
                DB_ACCEPT: begin
                    cnt    <= '0;
                    stable <= sync;
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Edge pulses, registered from stable and its previous value, so each
    // pulse is high for exactly the cycle after stable changes.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_prev <= 1'b0;
            rise_pulse  <= 1'b0;
            fall_pulse  <= 1'b0;
        end else begin
            stable_prev <= stable;
            rise_pulse  <= stable & ~stable_prev;
            fall_pulse  <= ~stable & stable_prev;
        end
    end

endmodule : gpio_debounce_bit

// File: rtl/gpio_in_debounce.sv
// -----------------------------------------------------------------------------
// gpio_in_debounce
//   Input conditioning between the ZedBoard switch/button pins and the core
//   GPIO peripheral. Every bit is synchronised, debounced and edge-detected by
//   its own gpio_debounce_bit; enabled edges latch into sticky pending flags,
//   and a registered OR of those flags forms the level interrupt request.
//
//   Parameters
//     WIDTH            number of input pins (sw + btn)
//     SYNC_STAGES      synchroniser depth (min 2)
//     DEBOUNCE_CYCLES  consecutive stable cycles needed to accept a new level
//     CNT_W            counter width, 2**CNT_W > DEBOUNCE_CYCLES
//
//   Ports
//     clk          in   system clock, 125 MHz
//     rst_n        in   asynchronous active-low reset
//     gpio_pin_in  in   raw asynchronous board pins
//     rise_en      in   per-bit: a rising edge sets pending
//     fall_en      in   per-bit: a falling edge sets pending
//     pend_clr     in   per-bit write-1-to-clear of pending (one-cycle pulse)
//     gpio_stable  out  debounced levels for the GPIO data register
//     rise_pulse   out  one-cycle pulse per bit on a 0->1 of gpio_stable
//     fall_pulse   out  one-cycle pulse per bit on a 1->0 of gpio_stable
//     pend         out  sticky edge-pending flags
//     irq          out  registered OR of pend
// -----------------------------------------------------------------------------
module gpio_in_debounce
    import rw_gpio_pkg::*;
#(
    parameter int unsigned WIDTH           = GPIO_IN_WIDTH,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_1MS,
    parameter int unsigned CNT_W           = DEBOUNCE_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] gpio_pin_in,
    input  logic [WIDTH-1:0] rise_en,
    input  logic [WIDTH-1:0] fall_en,
    input  logic [WIDTH-1:0] pend_clr,
    output logic [WIDTH-1:0] gpio_stable,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic [WIDTH-1:0] pend,
    output logic             irq
);

    logic [WIDTH-1:0] pend_set;
    logic [WIDTH-1:0] pend_next;

    // ---------------------------------------------------------------------
    // Per-bit conditioning.
    // ---------------------------------------------------------------------
    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        gpio_debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_bit (
            .clk        (clk),
            .rst_n      (rst_n),
            .pin        (gpio_pin_in[g]),
            .stable     (gpio_stable[g]),
            .rise_pulse (rise_pulse[g]),
            .fall_pulse (fall_pulse[g])
        );
    end

    // ---------------------------------------------------------------------
    // Pending flags. A set term is ORed in after the clear is applied, so an
    // edge arriving in the same cycle as pend_clr is kept. Enables only gate
    // new edges; dropping one leaves an existing flag alone.
    // ---------------------------------------------------------------------
    always_comb begin
        pend_set  = (rise_pulse & rise_en) | (fall_pulse & fall_en);
        pend_next = pend_set | (pend & ~pend_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
            irq  <= 1'b0;
        end else begin
            pend <= pend_next;
            irq  <= |pend;
        end
    end

endmodule : gpio_in_debounce

// File: tb/tb_gpio_in_debounce.sv
module tb_gpio_in_debounce;

    localparam int W = 13;

    typedef struct packed {
        logic [W-1:0] stable;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic [W-1:0] pnd;
        logic         irq;
    } snap_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] gpio_pin_in;
    logic [W-1:0] rise_en;
    logic [W-1:0] fall_en;
    logic [W-1:0] pend_clr;
    logic [W-1:0] gpio_stable;
    logic [W-1:0] rise_pulse;
    logic [W-1:0] fall_pulse;
    logic [W-1:0] pend;
    logic         irq;

    snap_t sb[$];
    int    tests_run    = 0;
    int    tests_failed = 0;

    always #4 clk = ~clk;

    gpio_in_debounce #(
        .WIDTH           (W),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .gpio_pin_in (gpio_pin_in),
        .rise_en     (rise_en),
        .fall_en     (fall_en),
        .pend_clr    (pend_clr),
        .gpio_stable (gpio_stable),
        .rise_pulse  (rise_pulse),
        .fall_pulse  (fall_pulse),
        .pend        (pend),
        .irq         (irq)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic snap_t sample();
        snap_t s;
        s.stable = gpio_stable;
        s.rise   = rise_pulse;
        s.fall   = fall_pulse;
        s.pnd    = pend;
        s.irq    = irq;
        return s;
    endfunction

    // Reset hold with all pins high, then release: accept at edge 6, rise at 7.
    task automatic test_reset;
        snap_t e, a;
        rst_n = 1'b0; gpio_pin_in = '1;
        rise_en = '0; fall_en = '0; pend_clr = '0;
        repeat (3) tick;
        a = sample();
        tests_run++;
        if (a !== snap_t'(0)) begin
            tests_failed++;
            $display("FAIL reset_hold: got %h want 0", a);
        end
        rst_n = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            e = '0;
            if (i >= 6) e.stable = '1;
            if (i == 7) e.rise = '1;
            sb.push_back(e);
        end
        for (int i = 1; i <= 9; i++) begin
            tick;
            a = sample();
            e = sb.pop_front();
            tests_run++;
            if (a !== e) begin
                tests_failed++;
                $display("FAIL reset_release edge %0d: stable/rise/fall/pend/irq got %h/%h/%h/%h/%b want %h/%h/%h/%h/%b",
                         i, a.stable, a.rise, a.fall, a.pnd, a.irq, e.stable, e.rise, e.fall, e.pnd, e.irq);
            end
        end
    endtask

    // Bit 3 clean 0->1 step.
    task automatic test_rise_step;
        snap_t e, a;
        gpio_pin_in = '0;
        repeat (12) tick;
        gpio_pin_in[3] = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            e = '0;
            if (i >= 6) e.stable = 13'h0008;
            if (i == 7) e.rise = 13'h0008;
            sb.push_back(e);
        end
        for (int i = 1; i <= 9; i++) begin
            tick;
            a = sample();
            e = sb.pop_front();
            tests_run++;
            if (a !== e) begin
                tests_failed++;
                $display("FAIL rise_step edge %0d: stable/rise/fall/pend/irq got %h/%h/%h/%h/%b want %h/%h/%h/%h/%b",
                         i, a.stable, a.rise, a.fall, a.pnd, a.irq, e.stable, e.rise, e.fall, e.pnd, e.irq);
            end
        end
    endtask

    // Bit 5 high for 3 clk, low for 1, three times: never accepted.
    task automatic test_glitch;
        snap_t e, a;
        for (int i = 1; i <= 18; i++) begin
            gpio_pin_in[5] = (i <= 12) && (((i - 1) % 4) < 3);
            e = '0;
            e.stable = 13'h0008;
            sb.push_back(e);
            tick;
            a = sample();
            e = sb.pop_front();
            tests_run++;
            if (a !== e) begin
                tests_failed++;
                $display("FAIL glitch edge %0d: stable/rise/fall/pend/irq got %h/%h/%h/%h/%b want %h/%h/%h/%h/%b",
                         i, a.stable, a.rise, a.fall, a.pnd, a.irq, e.stable, e.rise, e.fall, e.pnd, e.irq);
            end
        end
    endtask

    // Rise enable on bit 0: pend then irq; write-1-to-clear drops both.
    task automatic test_pend_rise;
        snap_t e, a;
        rise_en = 13'h0001;
        for (int i = 1; i <= 13; i++) begin
            if (i == 1) gpio_pin_in[0] = 1'b1;
            pend_clr = (i == 11) ? 13'h0001 : 13'h0000;
            e = '0;
            e.stable = (i >= 6) ? 13'h0009 : 13'h0008;
            if (i == 7) e.rise = 13'h0001;
            if (i >= 8 && i <= 10) e.pnd = 13'h0001;
            e.irq = (i >= 9 && i <= 11);
            sb.push_back(e);
            tick;
            a = sample();
            e = sb.pop_front();
            tests_run++;
            if (a !== e) begin
                tests_failed++;
                $display("FAIL pend_rise edge %0d: stable/rise/fall/pend/irq got %h/%h/%h/%h/%b want %h/%h/%h/%h/%b",
                         i, a.stable, a.rise, a.fall, a.pnd, a.irq, e.stable, e.rise, e.fall, e.pnd, e.irq);
            end
        end
        pend_clr = '0;
        rise_en  = '0;
    endtask

    // Fall on bit 1 with pend_clr in the same cycle: set wins; then the
    // enable is dropped and the flag must stay.
    task automatic test_set_wins;
        snap_t e, a;
        gpio_pin_in[1] = 1'b1;
        repeat (12) tick;
        fall_en = 13'h0002;
        for (int i = 1; i <= 11; i++) begin
            if (i == 1) gpio_pin_in[1] = 1'b0;
            pend_clr = (i == 8) ? 13'h0002 : 13'h0000;
            if (i == 9) fall_en = '0;
            e = '0;
            e.stable = (i >= 6) ? 13'h0009 : 13'h000B;
            if (i == 7) e.fall = 13'h0002;
            if (i >= 8) e.pnd = 13'h0002;
            e.irq = (i >= 9);
            sb.push_back(e);
            tick;
            a = sample();
            e = sb.pop_front();
            tests_run++;
            if (a !== e) begin
                tests_failed++;
                $display("FAIL set_wins edge %0d: stable/rise/fall/pend/irq got %h/%h/%h/%h/%b want %h/%h/%h/%h/%b",
                         i, a.stable, a.rise, a.fall, a.pnd, a.irq, e.stable, e.rise, e.fall, e.pnd, e.irq);
            end
        end
        pend_clr = 13'h0002;
        tick;
        pend_clr = '0;
        tick;
        tests_run++;
        if (pend !== 13'h0000 || irq !== 1'b0) begin
            tests_failed++;
            $display("FAIL set_wins_cleanup: pend/irq got %h/%b want 0000/0", pend, irq);
        end
    endtask

    // Bit 7 mid-debounce (cnt=2) when reset pulses for one clk.
    task automatic test_reset_mid;
        snap_t e, a;
        for (int i = 1; i <= 4; i++) begin
            if (i == 1) gpio_pin_in[7] = 1'b1;
            e = '0;
            e.stable = 13'h0009;
            sb.push_back(e);
            tick;
            a = sample();
            e = sb.pop_front();
            tests_run++;
            if (a !== e) begin
                tests_failed++;
                $display("FAIL reset_mid_pre edge %0d: stable got %h want %h", i, a.stable, e.stable);
            end
        end
        rst_n = 1'b0;
        #1;
        a = sample();
        tests_run++;
        if (a !== snap_t'(0)) begin
            tests_failed++;
            $display("FAIL reset_mid_async: got %h want 0", a);
        end
        tick;
        rst_n = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            e = '0;
            if (j >= 6) e.stable = 13'h0089;
            if (j == 7) e.rise = 13'h0089;
            sb.push_back(e);
        end
        for (int j = 1; j <= 8; j++) begin
            tick;
            a = sample();
            e = sb.pop_front();
            tests_run++;
            if (a !== e) begin
                tests_failed++;
                $display("FAIL reset_mid_release edge %0d: stable/rise/fall/pend/irq got %h/%h/%h/%h/%b want %h/%h/%h/%h/%b",
                         j, a.stable, a.rise, a.fall, a.pnd, a.irq, e.stable, e.rise, e.fall, e.pnd, e.irq);
            end
        end
    endtask

    initial begin
        test_reset;
        test_rise_step;
        test_glitch;
        test_pend_rise;
        test_set_wins;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_gpio_in_debounce
